// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of NUM_PORTS valid/ready streams into one registered output stream.
// Define STREAM_ARB_TID_EN to add out_tid, the source port of each output beat.
module stream_rr_arbiter #(
   parameter int DATA_SIZE = 16,
   parameter int NUM_PORTS = 4,
   parameter int BURST_LEN = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NUM_PORTS*DATA_SIZE-1:0] in_tdata,
   input  logic [NUM_PORTS-1:0]           in_tvalid,
   output logic [NUM_PORTS-1:0]           in_tready,
   output logic [DATA_SIZE-1:0]           out_tdata,
   output logic                           out_tvalid,
`ifdef STREAM_ARB_TID_EN
   output logic [$clog2(NUM_PORTS)-1:0]   out_tid,
`endif
   input  logic                           out_tready
);

   localparam int PW = $clog2(NUM_PORTS);
   localparam int CW = $clog2(BURST_LEN + 1);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t               r_state;
   logic [PW-1:0]        r_g;
   logic [PW-1:0]        r_ptr;
   logic [CW-1:0]        r_cnt;
   logic [DATA_SIZE-1:0] r_out_tdata;
   logic                 r_out_tvalid;
`ifdef STREAM_ARB_TID_EN
   logic [PW-1:0]        r_out_tid;
`endif

   logic                 w_ready;
   logic                 w_accept;
   logic                 w_last_beat;
   logic                 w_any_valid;
   logic [PW-1:0]        w_next_g;
   logic [PW-1:0]        w_g_inc;
   logic [PW:0]          w_idx;
   logic [DATA_SIZE-1:0] w_sel_data;

   // A beat moves on any edge where valid && ready; ready never depends on the same port's valid,
   // and the output register only refills when it is empty or being drained this cycle.
   assign w_ready     = (r_state == S_GRANT) && (!r_out_tvalid || out_tready) && !rst_i;
   assign w_accept    = w_ready && in_tvalid[r_g];
   assign w_last_beat = (r_cnt == CW'(BURST_LEN - 1));
   assign w_any_valid = |in_tvalid;
   assign w_g_inc     = (r_g == PW'(NUM_PORTS - 1)) ? '0 : r_g + PW'(1);
   assign w_sel_data  = in_tdata[r_g*DATA_SIZE +: DATA_SIZE];

   // Walk the ports from the highest offset down so the nearest valid port after ptr wins.
   always_comb begin
      w_next_g = r_ptr;
      w_idx    = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         w_idx = {1'b0, r_ptr} + (PW+1)'(i);
         if (w_idx >= (PW+1)'(NUM_PORTS)) begin
            w_idx = w_idx - (PW+1)'(NUM_PORTS);
         end
         if (in_tvalid[w_idx[PW-1:0]]) begin
            w_next_g = w_idx[PW-1:0];
         end
      end
   end

   always_comb begin
      in_tready = '0;
      if (w_ready) begin
         in_tready[r_g] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_g          <= '0;
         r_ptr        <= '0;
         r_cnt        <= '0;
         r_out_tdata  <= '0;
         r_out_tvalid <= 1'b0;
`ifdef STREAM_ARB_TID_EN
         r_out_tid    <= '0;
`endif
      end else begin
         if (w_accept) begin
            r_out_tdata  <= w_sel_data;
            r_out_tvalid <= 1'b1;
`ifdef STREAM_ARB_TID_EN
            r_out_tid    <= r_g;
`endif
         end else if (out_tready) begin
            r_out_tvalid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_any_valid) begin
                  r_g     <= w_next_g;
                  r_cnt   <= '0;
                  r_state <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (!in_tvalid[r_g]) begin
                  r_state <= S_IDLE;
                  r_ptr   <= w_g_inc;
               end else if (w_accept) begin
                  r_cnt <= r_cnt + CW'(1);
                  if (w_last_beat) begin
                     r_state <= S_IDLE;
                     r_ptr   <= w_g_inc;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign out_tdata  = r_out_tdata;
   assign out_tvalid = r_out_tvalid;
`ifdef STREAM_ARB_TID_EN
   assign out_tid    = r_out_tid;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: per-port source queues drive the inputs, an expected queue
// holds each output beat with its expected spacing (and source port when STREAM_ARB_TID_EN).
module tb_stream_rr_arbiter;

   localparam int NP = 4;
   localparam int DW = 16;
   localparam int BL = 4;

   // clock / reset
   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;

   logic [NP*DW-1:0] in_tdata;
   logic [NP-1:0]    in_tvalid;
   logic [NP-1:0]    in_tready;
   logic [DW-1:0]    out_tdata;
   logic             out_tvalid;
   logic             out_tready;
`ifdef STREAM_ARB_TID_EN
   logic [1:0]       out_tid;
`endif

   stream_rr_arbiter #(.DATA_SIZE(DW), .NUM_PORTS(NP), .BURST_LEN(BL)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .in_tdata   (in_tdata),
      .in_tvalid  (in_tvalid),
      .in_tready  (in_tready),
      .out_tdata  (out_tdata),
      .out_tvalid (out_tvalid),
`ifdef STREAM_ARB_TID_EN
      .out_tid    (out_tid),
`endif
      .out_tready (out_tready)
   );

   int            check_n = 0;
   int            fail_n  = 0;
   int            cyc_n   = 0;
   int            last_xfer = 0;
   int            stall_left = 0;
   int            stall_seen = 0;
   logic          stall_arm = 1'b0;
   logic          stall_chk = 1'b0;
   logic          rand_bp   = 1'b0;
   logic [DW-1:0] stall_data = '0;
   logic [NP-1:0] ready_or = '0;

   logic [DW-1:0] exp_q[$];
   int            gap_q[$];
   int            tid_q[$];
   logic [DW-1:0] src_q[NP][$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_n++;
      if (got !== exp) begin
         fail_n++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc_n);
      end
   endtask

   task automatic exp_push(input logic [DW-1:0] d, input int gap, input int tid);
      exp_q.push_back(d);
      gap_q.push_back(gap);
      tid_q.push_back(tid);
   endtask

   task automatic exp_burst(input logic [DW-1:0] base, input int n, input int first_gap, input int tid);
      for (int i = 0; i < n; i++) begin
         exp_push(base + DW'(i), (i == 0) ? first_gap : 1, tid);
      end
   endtask

   task automatic src_load(input int p, input logic [DW-1:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         src_q[p].push_back(base + DW'(i));
      end
   endtask

   task automatic drive_inputs();
      logic [NP*DW-1:0] d;
      logic [NP-1:0]    v;
      d = '0;
      v = '0;
      for (int p = 0; p < NP; p++) begin
         if (src_q[p].size() > 0) begin
            v[p]           = 1'b1;
            d[p*DW +: DW]  = src_q[p][0];
         end
      end
      in_tvalid = v;
      in_tdata  = d;
   endtask

   // One clock: monitor at the falling edge, update drivers 1 time unit after the rising edge.
   task automatic cycle();
      logic [NP-1:0] acc;
      logic [DW-1:0] ed;
      int            eg;
      int            et;
      @(negedge clk_i);
      cyc_n++;
      acc = in_tvalid & in_tready;
      if (!rst_i) begin
         ready_or |= in_tready;
         if (stall_chk && !out_tready) begin
            stall_seen++;
            check("stall_valid", 32'(out_tvalid), 32'd1);
            check("stall_data", 32'(out_tdata), 32'(stall_data));
            check("stall_ready", 32'(in_tready), 32'd0);
         end
         if (out_tvalid && out_tready) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", 32'(exp_q.size()), 32'd1);
            end else begin
               ed = exp_q.pop_front();
               eg = gap_q.pop_front();
               et = tid_q.pop_front();
               check("beat_data", 32'(out_tdata), 32'(ed));
               if (eg > 0) check("beat_gap", 32'(cyc_n - last_xfer), 32'(eg));
`ifdef STREAM_ARB_TID_EN
               check("beat_tid", 32'(out_tid), 32'(et));
`else
               if (et < 0) check("beat_tid_range", 32'(et), 32'd0);
`endif
            end
            last_xfer = cyc_n;
         end
      end
      @(posedge clk_i);
      #1;
      for (int p = 0; p < NP; p++) begin
         if (acc[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
      end
      if (stall_arm && out_tvalid && out_tdata == stall_data) begin
         stall_left = 3;
         stall_arm  = 1'b0;
      end
      if (stall_left > 0) begin
         out_tready = 1'b0;
         stall_left--;
      end else begin
         out_tready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      drive_inputs();
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         cycle();
         n++;
      end
      check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      gap_q.delete();
      tid_q.delete();
      repeat (3) cycle();
   endtask

   initial begin
      int n;
      int p;
      int len;
      logic [DW-1:0] d;

      rst_i      = 1'b1;
      out_tready = 1'b1;

      // reset with every port requesting, then fairness from port 0
      src_load(0, 16'h0000, 8);
      src_load(1, 16'h0100, 4);
      src_load(2, 16'h0200, 4);
      src_load(3, 16'h0300, 4);
      exp_burst(16'h0000, 4, -1, 0);
      exp_burst(16'h0100, 4, 2, 1);
      exp_burst(16'h0200, 4, 2, 2);
      exp_burst(16'h0300, 4, 2, 3);
      exp_burst(16'h0004, 4, 2, 0);
      drive_inputs();
      for (int i = 0; i < 2; i++) begin
         @(posedge clk_i);
         #1;
         check("rst_tvalid", 32'(out_tvalid), 32'd0);
         check("rst_tdata", 32'(out_tdata), 32'd0);
         check("rst_tready", 32'(in_tready), 32'd0);
      end
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      check("rst_first_grant", 32'(in_tready), 32'h1);
      drain("fair", 200);

      // reset in the middle of a port-1 burst; arbitration must restart at port 0
      src_load(1, 16'h1100, 4);
      src_load(0, 16'h0B00, 4);
      drive_inputs();
      n = 0;
      while (!out_tvalid && n < 20) begin
         cycle();
         n++;
      end
      check("mid_first_src", 32'(out_tdata), 32'h1100);
      rst_i = 1'b1;
      drive_inputs();
      @(posedge clk_i);
      #1;
      check("mid_rst_tvalid", 32'(out_tvalid), 32'd0);
      check("mid_rst_tdata", 32'(out_tdata), 32'd0);
      check("mid_rst_tready", 32'(in_tready), 32'd0);
      for (int q = 0; q < NP; q++) src_q[q].delete();
      src_load(0, 16'h0A00, 2);
      src_load(1, 16'h1A00, 2);
      exp_burst(16'h0A00, 2, -1, 0);
      exp_burst(16'h1A00, 2, 3, 1);
      rst_i = 1'b0;
      drive_inputs();
      drain("restart", 100);

      // single port, six beats: burst of four, bubble, two more
      ready_or = '0;
      src_load(2, 16'h0200, 6);
      exp_burst(16'h0200, 4, -1, 2);
      exp_burst(16'h0204, 2, 2, 2);
      drive_inputs();
      drain("single", 100);
      check("single_ready_mask", 32'(ready_or), 32'h4);

      // backpressure for three cycles while the second beat of port 0 is held
      stall_data = 16'h0C01;
      stall_arm  = 1'b1;
      stall_chk  = 1'b1;
      stall_seen = 0;
      src_load(0, 16'h0C00, 4);
      exp_push(16'h0C00, -1, 0);
      exp_push(16'h0C01, 4, 0);
      exp_push(16'h0C02, 1, 0);
      exp_push(16'h0C03, 1, 0);
      drive_inputs();
      drain("bp", 100);
      check("bp_stall_cycles", 32'(stall_seen), 32'd3);
      stall_chk = 1'b0;

      // early release of port 1: ptr moves to 2 so port 3 beats port 0
      src_load(1, 16'h1111, 2);
      src_load(3, 16'h3300, 6);
      src_load(0, 16'h0D00, 2);
      exp_burst(16'h1111, 2, -1, 1);
      exp_burst(16'h3300, 4, 3, 3);
      exp_burst(16'h0D00, 2, 2, 0);
      exp_burst(16'h3304, 2, 3, 3);
      drive_inputs();
      drain("early", 120);

      // random data and lengths under random output backpressure
      rand_bp = 1'b1;
      for (int it = 0; it < 4; it++) begin
         p   = $urandom_range(0, NP - 1);
         len = $urandom_range(1, 10);
         for (int i = 0; i < len; i++) begin
            d = DW'($urandom_range(0, 65535));
            src_q[p].push_back(d);
            exp_push(d, -1, p);
         end
         drive_inputs();
         drain("rand", 400);
      end
      rand_bp = 1'b0;
      repeat (2) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", check_n, fail_n);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout at cycle %0d", cyc_n);
      $fatal(1, "watchdog");
   end

endmodule
